arm_multicycle_ctrl: RTL

- Main control FSM for the multicycle ARM core. It sequences one shared ALU, register file port and unified instruction/data memory over several cycles per instruction.
- Consumes the same instruction fields as the single-cycle decoder (Op, Funct, Rd, Instr[7:4]) plus the condition-check result. Emits per-cycle mux selects and write enables.
- ALUControl/FlagW decode stays in the existing ALU decoder, gated by this block's ALUOp.
- Also provides an instruction-retire pulse and a retired-instruction counter.

---
 rtl/arm_multicycle_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Main control FSM for the multicycle ARM core. It sequences fetch, decode, execute, memory and writeback,
// and counts retired instructions. Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module arm_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic [3:0]       Instr,
  input  logic             cond_ex,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             linkSelect,
  output logic             PCS,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    LINK     = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  state_t state, state_next;
  logic   mem_ok;
  logic   unused_bits;

`ifdef MEM_WAIT_EN
  assign mem_ok      = mem_ready;
  assign unused_bits = ^{Funct[2:1], Instr[2:1]};
`else
  assign mem_ok      = 1'b1;
  assign unused_bits = ^{Funct[2:1], Instr[2:1], mem_ready};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = FETCH;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    linkSelect = 1'b0;
    instr_done = 1'b0;

    case (state)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ok) begin
          IRWrite    = 1'b1;
          NextPC     = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // A failed condition or an undefined opcode retires here and returns to FETCH.
        if (!cond_ex) begin
          instr_done = 1'b1;
        end else begin
          case (Op)
            2'b00: begin
              if (!Funct[5] && Instr[3] && Instr[0]) state_next = MEMADR;
              else if (Funct[5])                     state_next = EXECUTEI;
              else                                   state_next = EXECUTER;
            end
            2'b01:   state_next = MEMADR;
            2'b10:   state_next = Funct[4] ? LINK : BRANCH;
            default: instr_done = 1'b1;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ok ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (mem_ok) instr_done = 1'b1;
        else        state_next = MEMWRITE;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB = (state == EXECUTEI) ? 2'b01 : 2'b00;
        ALUOp   = 1'b1;
        if (Funct[4:3] == 2'b10) instr_done = 1'b1;
        else                     state_next = ALUWB;
      end
      ALUWB: begin
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      LINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        RegW       = 1'b1;
        linkSelect = 1'b1;
        state_next = BRANCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: state_next = FETCH;
    endcase

    // Reset masks everything so no write completes in the cycle it is asserted.
    if (reset) begin
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUOp      = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      Branch     = 1'b0;
      linkSelect = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign PCS = (RegW && (Rd == 4'hF)) || Branch;

endmodule
